// File: rtl/divide.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// held with a single-cycle done pulse until the next accepted start.
module divide #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last_iter;
    logic             divisor_zero;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             sub_ok;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    assign accept       = start && (state_reg != RUN);
    assign last_iter    = (count_reg == CW'(WIDTH - 1));
    assign divisor_zero = (divisor == '0);

    // Partial remainder never reaches 2^WIDTH after a restore, so only WIDTH
    // bits are stored; the trial subtract itself runs over WIDTH+1 bits.
    assign trial  = {r_reg, q_reg[WIDTH-1]};
    assign diff   = trial - {1'b0, d_reg};
    assign sub_ok = ~diff[WIDTH];
    assign r_step = sub_ok ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    assign q_step[0] = sub_ok;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_qshift
            assign q_step[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = divisor_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            count_reg     <= '0;
            d_reg         <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            count_reg <= '0;
            d_reg     <= divisor;
            q_reg     <= dividend;
            r_reg     <= '0;
            dbz_reg   <= divisor_zero;
            if (divisor_zero) begin
                quotient_reg  <= '1;
                remainder_reg <= dividend;
            end
        end else if (state_reg == RUN) begin
            count_reg <= count_reg + CW'(1);
            q_reg     <= q_step;
            r_reg     <= r_step;
            if (last_iter) begin
                quotient_reg  <= q_step;
                remainder_reg <= r_step;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign div_by_zero = dbz_reg;

endmodule
